tpu_seq_ctrl: RTL
=================

Name: tpu_seq_ctrl

Overview:
Top-level sequencer for the 2x2 TPU datapath.
- Accepts a byte stream from the pins: 4 weight bytes, then 4 input bytes.
- Writes those bytes into the 8-entry operand memory and waits for the memory's registered outputs to settle.
- Pulses the systolic array start, waits for its done, captures the four 16-bit results and streams them out as 8 bytes over a valid/ready handshake.

Parameters:
SETTLE_CYCLES, 2, idle cycles between last memory write and compute_start (memory write + output-register stage)
RESULT_W, 16, width of each result element (must be 16; output serialisation is 2 bytes/element)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input byte valid
in_data  input  8  input byte
in_ready  output  1  controller accepts byte this cycle
mem_write_en  output  1  memory write strobe
mem_addr  output  3  memory address; bit2 = 0 weights, 1 inputs
mem_data  output  8  memory write data
compute_start  output  1  one-cycle start pulse to array
compute_done  input  1  array done pulse/level
results  input  64  four RESULT_W results, element k at bits [16k+15:16k]
out_valid  output  1  output byte valid
out_data  output  8  output byte
out_ready  input  1  consumer accepts byte
busy  output  1  high in any state except LOAD with load_cnt==0

Behaviour:
- Reset: synchronous, active-high, on clk. Sets state=LOAD, load_cnt=0, settle_cnt=0, out_cnt=0, result capture register=0. All outputs go to 0 except in_ready, which reads 1 in the first cycle after reset. Reset mid-operation aborts immediately; no further memory writes or start pulse occur.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, in the same cycle (combinational):
    - mem_write_en=1
    - mem_addr=load_cnt
    - mem_data=in_data
  - load_cnt increments on each accepted byte. Addresses 0..7 are written strictly in order.
  - After the accept at load_cnt==7: load_cnt wraps to 0 and state -> SETTLE.
  - in_valid low: no write, no count.
- SETTLE:
  - in_ready=0, mem_write_en=0.
  - settle_cnt counts SETTLE_CYCLES cycles, then state -> START.
  - compute_start rises exactly SETTLE_CYCLES+1 cycles after the last write cycle.
- START: compute_start=1 for exactly one cycle; state -> WAIT.
- WAIT:
  - Hold until compute_done=1.
  - In that cycle, capture `results` into a 64-bit register; out_cnt=0; state -> STREAM.
  - compute_done in any other state is ignored.
- STREAM:
  - out_valid=1.
  - out_data = byte out_cnt of the captured register. Order: element 0 high byte, element 0 low byte, element 1 high, ..., element 3 low (8 bytes).
  - out_data and out_valid are held stable while out_ready=0.
  - On out_valid&out_ready: out_cnt increments.
  - After the accept at out_cnt==7: out_valid drops next cycle, state -> LOAD, load_cnt=0.
  - in_ready=0 throughout STREAM; in_valid bytes are not consumed and not written.
- Outputs out_valid, out_data and compute_start come from registers. in_ready, mem_write_en, mem_addr and mem_data are decoded from state/counters plus in_valid/in_data.
- No back-to-back overlap: a new frame's first byte can be accepted the cycle after the last output byte is accepted.
- busy is low only in LOAD with load_cnt==0. It goes high the cycle after the first byte is accepted.

Decomposition:
- Shared package tpu_pkg holds:
  - state enum (LOAD, SETTLE, START, WAIT, STREAM)
  - WEIGHT_BASE=0, INPUT_BASE=4, MEM_DEPTH=8, RESULT_W=16, N_RESULTS=4
- One natural sub-module: tpu_result_serializer. It owns the capture register, out_cnt and the out_valid/out_ready handshake. The FSM keeps load/settle/start control.

Test Plan:
- Reset, then stream bytes 1,2,3,4,5,6,7,8 with in_valid held high -> mem writes addr 0..7 with data 1..8 on 8 consecutive cycles. compute_start is a single pulse 3 cycles after the addr-7 write.
- Same frame with in_valid toggling 1,0,1,0 -> writes only on valid cycles, addresses still contiguous 0..7, no write when in_valid=0.
- compute_done after 5 WAIT cycles with results {50,43,22,19} (element3..0); out_ready held high -> out_data sequence 0x00,0x13,0x00,0x16,0x00,0x2B,0x00,0x32, then in_ready=1.
- out_ready low for 3 cycles mid-stream at byte 2 -> out_data stays 0x00 and out_valid stays 1. The sequence resumes unchanged, with no byte lost or duplicated.
- Assert rst during SETTLE (after 8 writes) -> no compute_start. Next cycle all outputs 0, in_ready=1. A fresh 8-byte frame restarts at addr 0.
- Pulse compute_done during LOAD and during STREAM, and drive in_valid=1 during STREAM -> no state change, no capture, no memory writes.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the 2x2 TPU sequencer slice.
package tpu_pkg;
  typedef enum logic [2:0] {LOAD, SETTLE, START, WAIT, STREAM} state_e;

  localparam int WEIGHT_BASE = 0;
  localparam int INPUT_BASE  = 4;
  localparam int MEM_DEPTH   = 8;
  localparam int RESULT_W    = 16;
  localparam int N_RESULTS   = 4;
  localparam int ADDR_W      = $clog2(MEM_DEPTH);
endpackage

// File: rtl/tpu_seq_ctrl_if.sv
// Pin-side bundle of the sequencer: byte input, memory port, array control, byte output.
interface tpu_seq_ctrl_if;
  import tpu_pkg::*;

  logic                          in_valid;
  logic [7:0]                    in_data;
  logic                          in_ready;
  logic                          mem_write_en;
  logic [ADDR_W-1:0]             mem_addr;
  logic [7:0]                    mem_data;
  logic                          compute_start;
  logic                          compute_done;
  logic [N_RESULTS*RESULT_W-1:0] results;
  logic                          out_valid;
  logic [7:0]                    out_data;
  logic                          out_ready;
  logic                          busy;

  modport master (
    input  in_valid, in_data, compute_done, results, out_ready,
    output in_ready, mem_write_en, mem_addr, mem_data, compute_start,
           out_valid, out_data, busy
  );

  modport slave (
    output in_valid, in_data, compute_done, results, out_ready,
    input  in_ready, mem_write_en, mem_addr, mem_data, compute_start,
           out_valid, out_data, busy
  );
endinterface

// File: rtl/tpu_result_serializer.sv
// Captures the array results and streams them high byte first, element 0 first.
module tpu_result_serializer
  import tpu_pkg::*;
#(
  parameter int RES_W = 16,
  parameter int N_RES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_i,
  input  logic [N_RES-1:0][RES_W-1:0]      results_i,
  input  logic                             out_ready_i,
  output logic                             out_valid_o,
  output logic [7:0]                       out_data_o,
  output logic                             last_o
);
  localparam int NB = N_RES * RES_W / 8;
  localparam int CW = $clog2(NB);

  logic [N_RES-1:0][RES_W-1:0] cap_q;
  logic [CW-1:0]               out_cnt_q;
  logic                        out_valid_q;
  logic [7:0]                  out_data_q;
  logic                        accept;

  function automatic logic [7:0] byte_of(input logic [N_RES-1:0][RES_W-1:0] r,
                                         input logic [CW-1:0] k);
    logic [CW-2:0] e;
    e = k[CW-1:1];
    return k[0] ? r[e][7:0] : r[e][RES_W-1 -: 8];
  endfunction

  assign accept      = out_valid_q && out_ready_i;
  assign last_o      = accept && (out_cnt_q == CW'(NB - 1));
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q       <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load_i) begin
      cap_q       <= results_i;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b1;
      out_data_q  <= byte_of(results_i, '0);
    end else if (accept) begin
      out_cnt_q <= out_cnt_q + 1'b1;
      if (last_o) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        // Preload the next byte so out_data is a pure register.
        out_data_q <= byte_of(cap_q, CW'(out_cnt_q + 1'b1));
      end
    end
  end
endmodule

// File: rtl/tpu_seq_ctrl.sv
// Top-level sequencer: load 8 operand bytes, settle, start the array, stream results.
module tpu_seq_ctrl
  import tpu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int RESULT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  tpu_seq_ctrl_if.master io
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(WEIGHT_BASE);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(INPUT_BASE + (MEM_DEPTH - INPUT_BASE) - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] load_cnt_q;
  logic [SW-1:0]     settle_cnt_q;
  logic              start_q;
  logic              accept;
  logic              capture;
  logic              ser_last;

  assign io.in_ready      = (state_q == LOAD);
  assign accept           = io.in_valid && io.in_ready;
  // Address bit 2 splits weights (0..3) from inputs (4..7); writes are strictly in order.
  assign io.mem_write_en  = accept;
  assign io.mem_addr      = accept ? load_cnt_q : '0;
  assign io.mem_data      = accept ? io.in_data : '0;
  assign io.compute_start = start_q;
  assign io.busy          = !((state_q == LOAD) && (load_cnt_q == FIRST_ADDR));
  assign capture          = (state_q == WAIT) && io.compute_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      load_cnt_q   <= FIRST_ADDR;
      settle_cnt_q <= '0;
      start_q      <= 1'b0;
    end else begin
      case (state_q)
        LOAD: if (accept) begin
          load_cnt_q <= load_cnt_q + 1'b1;
          if (load_cnt_q == LAST_ADDR) begin
            state_q      <= SETTLE;
            settle_cnt_q <= '0;
          end
        end
        SETTLE: begin
          // Raise start on the transition so it lands SETTLE_CYCLES+1 after the last write.
          if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
            state_q      <= START;
            settle_cnt_q <= '0;
            start_q      <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        START: begin
          start_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: if (io.compute_done) state_q <= STREAM;
        STREAM: if (ser_last) begin
          state_q    <= LOAD;
          load_cnt_q <= FIRST_ADDR;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  tpu_result_serializer #(
    .RES_W (RESULT_W),
    .N_RES (N_RESULTS)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (capture),
    .results_i   (io.results),
    .out_ready_i (io.out_ready),
    .out_valid_o (io.out_valid),
    .out_data_o  (io.out_data),
    .last_o      (ser_last)
  );
endmodule
